transport_down: RTL and testbench
=================================

# transport_down

Downstream transport engine: accepts 64-bit frames from the host-side AXI-Stream slave (DMA/FIFO), buffers them in a 2-entry skid buffer, and presents them to the PAICore send interface under core back-pressure. It delimits each transfer with `s_axis_tlast`, then waits for the core to go idle before pulsing `o_tx_done` to the controller. It is the transmit-direction counterpart of the upstream transport.

## Interface
- `DONE_WAIT`, 4: consecutive idle cycles (core not busy, buffer empty) required before done; legal range 1..255.
- `s_axis_aclk`  in  1  sole clock; all logic is on its rising edge.
- `s_axis_aresetn`  in  1  reset; synchronous, active-low.
- `s_axis_tvalid`  in  1  host beat valid.
- `s_axis_tready`  out  1  block ready for a host beat.
- `s_axis_tdata`  in  64  host beat data.
- `s_axis_tlast`  in  1  last beat of the transfer.
- `s_axis_hsked`  out  1  `s_axis_tvalid & s_axis_tready`.
- `o_send_valid`  out  1  beat valid toward PAICore.
- `o_send_tdata`  out  64  beat data toward PAICore.
- `i_send_available`  in  1  PAICore accepts a beat this cycle.
- `i_send_busy`  in  1  PAICore still processing.
- `i_tx_sending`  in  1  controller enable, level.
- `o_tx_busy`  out  1  high in RUN or DRAIN.
- `o_tx_done`  out  1  one-cycle pulse when a transfer has completed.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `s_axis_tready`=0. Go to RUN on a rising edge of `i_tx_sending`, detected as current 1 with registered previous 0. A level held high after DONE does not re-arm.
- RUN: `s_axis_tready` = (cnt != 2), driven from registered state only, with no combinational path from `i_send_available`. Each handshake pushes the beat. Handshake with `s_axis_tlast`=1 goes to DRAIN.
- DRAIN: `s_axis_tready`=0. The buffer keeps emptying. The idle counter increments when cnt==0 and `i_send_busy`==0, and clears otherwise. Reaching `DONE_WAIT` goes to DONE.
- DONE: `o_tx_done`=1 for exactly one cycle, then IDLE.
- Abort: `i_tx_sending`==0 in RUN or DRAIN goes to IDLE on the next edge. The buffer is flushed (cnt=0), the idle counter is cleared, and no done pulse is issued.
- Skid buffer: 2 entries, with a head register and a spare register, and cnt 0..2.
  - `o_send_valid` = (cnt != 0). `o_send_tdata` = head.
  - Pop = `o_send_valid & i_send_available`. Push = `s_axis_hsked`.
  - Push and pop at cnt==1: cnt stays 1 and head loads the new beat.
  - Pop at cnt==2: head loads the spare.
  - Push at cnt==2 is impossible because tready is low.
- Beat data, including the tlast beat, is forwarded unmodified, in order, with no drops or duplicates.

## Timing
- Reset values: `s_axis_tready`=0, `o_send_valid`=0, `o_send_tdata`=0, `o_tx_busy`=0, `o_tx_done`=0. State is IDLE, cnt=0, idle counter=0, edge register=0.
- Latency: a beat handshaken at edge N is on `o_send_valid`/`o_send_tdata` from edge N onward, i.e. visible in cycle N+1.
- Throughput: with `i_send_available` held at 1, one beat per cycle is sustained.
- Hold rule: while `o_send_valid`=1 and `i_send_available`=0, `o_send_tdata` is stable.
- Done timing: the last pop at edge P with `i_send_busy`=0 thereafter gives `o_tx_done` high in cycle P+`DONE_WAIT`+1.
- Reset asserted mid-transfer: all state returns to reset values on that edge, buffered data is lost, and no done pulse is issued.

## Configuration
- `TRANSPORT_DOWN_FRAME_CNT_EN`
  - Defined: adds output `o_tx_beat_cnt` (32 bits). The count clears on the IDLE-to-RUN transition, increments on each `s_axis_hsked`, wraps at 2^32, and holds its value after DONE or abort until the next start. It resets to 0.
  - Undefined: the port and its counter do not exist, and all other behaviour is identical.

## Test plan
- Reset, then a rising edge on `i_tx_sending`, then 8 beats 0x1..0x8 with tlast on the 8th, with `i_send_available`=1 and `i_send_busy`=0:
  - `o_send_tdata` is 0x1..0x8 on 8 consecutive cycles.
  - `o_tx_done` pulses once, `DONE_WAIT`+1 cycles after the last pop.
  - `o_tx_busy` falls with the pulse.
- Back-pressure with `i_send_available` toggling 1,0,0,1 while the host streams continuously:
  - cnt never exceeds 2.
  - `s_axis_tready` drops at cnt==2.
  - Data stays stable while stalled, and no beat is lost.
- `i_send_busy` held high for 20 cycles after the buffer empties:
  - No done during the busy window.
  - Done appears `DONE_WAIT` cycles after busy falls.
  - A busy glitch mid-count restarts the count.
- Deassert `i_tx_sending` after 3 of 6 beats, with 2 beats buffered:
  - The next cycle is IDLE with `o_send_valid`=0 and `s_axis_tready`=0.
  - `o_tx_done` is never asserted.
- `i_tx_sending` held high across DONE: the block stays in IDLE with tready=0. A low-then-high toggle restarts the block.
- With the macro defined, send 5 beats: `o_tx_beat_cnt`=5 after done, and it clears to 0 on the next start.

Source files
------------

// File: rtl/transport_down.sv
// Host AXI-Stream to PAICore send path: 2-entry skid buffer (beat visible the cycle after handshake),
// tready from registered fill level only; optional TRANSPORT_DOWN_FRAME_CNT_EN adds o_tx_beat_cnt.
module transport_down #(
  parameter int DONE_WAIT = 4
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_aresetn,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  output logic        s_axis_hsked,
  output logic        o_send_valid,
  output logic [63:0] o_send_tdata,
  input  logic        i_send_available,
  input  logic        i_send_busy,
  input  logic        i_tx_sending,
  output logic        o_tx_busy,
`ifdef TRANSPORT_DOWN_FRAME_CNT_EN
  output logic [31:0] o_tx_beat_cnt,
`endif
  output logic        o_tx_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [7:0] DONE_WAIT_C = 8'(DONE_WAIT);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [63:0] head_q, head_d;
  logic [63:0] spare_q, spare_d;
  logic [7:0]  idle_q, idle_d;
  logic        sending_q;
  logic        start, abort, push, pop;

  assign start         = i_tx_sending & ~sending_q;
  assign abort         = ~i_tx_sending & ((state_q == RUN) || (state_q == DRAIN));
  assign s_axis_tready = (state_q == RUN) && (cnt_q != 2'd2);
  assign s_axis_hsked  = s_axis_tvalid & s_axis_tready;
  assign push          = s_axis_hsked;
  assign o_send_valid  = (cnt_q != 2'd0);
  assign o_send_tdata  = head_q;
  assign pop           = o_send_valid & i_send_available;
  assign o_tx_busy     = (state_q == RUN) || (state_q == DRAIN);
  assign o_tx_done     = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    case (state_q)
      IDLE: begin
        idle_d = 8'd0;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (abort)                     state_d = IDLE;
        else if (push && s_axis_tlast) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
          idle_d  = 8'd0;
        end else if ((cnt_q == 2'd0) && !i_send_busy) begin
          idle_d = idle_q + 8'd1;
          if (idle_d == DONE_WAIT_C) state_d = DONE;
        end else begin
          idle_d = 8'd0;
        end
      end
      DONE: begin
        state_d = IDLE;
        idle_d  = 8'd0;
      end
      default: begin
        state_d = IDLE;
        idle_d  = 8'd0;
      end
    endcase
  end

  // Head always holds the oldest beat; spare only fills when the head is stalled.
  always_comb begin
    cnt_d   = cnt_q;
    head_d  = head_q;
    spare_d = spare_q;
    if (abort) begin
      cnt_d = 2'd0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push) begin
            head_d = s_axis_tdata;
            cnt_d  = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_d = s_axis_tdata;
          end else if (push) begin
            spare_d = s_axis_tdata;
            cnt_d   = 2'd2;
          end else if (pop) begin
            cnt_d = 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_d = spare_q;
            cnt_d  = 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      head_q    <= 64'd0;
      spare_q   <= 64'd0;
      idle_q    <= 8'd0;
      sending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      spare_q   <= spare_d;
      idle_q    <= idle_d;
      sending_q <= i_tx_sending;
    end
  end

`ifdef TRANSPORT_DOWN_FRAME_CNT_EN
  logic [31:0] beat_q, beat_d;

  always_comb begin
    beat_d = beat_q;
    if ((state_q == IDLE) && start) beat_d = 32'd0;
    else if (push)                  beat_d = beat_q + 32'd1;
  end

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) beat_q <= 32'd0;
    else                 beat_q <= beat_d;
  end

  assign o_tx_beat_cnt = beat_q;
`endif

endmodule

// File: tb/tb_transport_down.sv
// Scoreboard bench for transport_down: driver queues expected beats, negedge monitor checks pops and done timing.
module tb_transport_down;
  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        rst_n, tvalid, tready, tlast, hsked;
  logic        send_valid, busy_in, sending, tx_busy, tx_done;
  logic        avail = 1'b0;
  logic [63:0] tdata, send_tdata;
`ifdef TRANSPORT_DOWN_FRAME_CNT_EN
  logic [31:0] beat_cnt;
`endif

  transport_down #(.DONE_WAIT(DW)) dut (
    .s_axis_aclk      (clk),
    .s_axis_aresetn   (rst_n),
    .s_axis_tvalid    (tvalid),
    .s_axis_tready    (tready),
    .s_axis_tdata     (tdata),
    .s_axis_tlast     (tlast),
    .s_axis_hsked     (hsked),
    .o_send_valid     (send_valid),
    .o_send_tdata     (send_tdata),
    .i_send_available (avail),
    .i_send_busy      (busy_in),
    .i_tx_sending     (sending),
    .o_tx_busy        (tx_busy),
`ifdef TRANSPORT_DOWN_FRAME_CNT_EN
    .o_tx_beat_cnt    (beat_cnt),
`endif
    .o_tx_done        (tx_done)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [63:0] exp_q[$];
  bit          mon_en = 0, run_phase = 0, done_allowed = 0, bp_mode = 0, avail_cmd = 0;
  int          last_pop_edge = 0, first_pop_edge = -1, done_ref = -1, done_count = 0;
  bit          hold_vld = 0, prev_busy = 0;
  logic [63:0] hold_dat = 64'd0;
  logic [3:0]  bp_pat = 4'b1001;
  int          bp_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Sink availability changes 2 time units after each edge, so the driver's +1 updates take effect in the same cycle.
  always @(posedge clk) begin
    #2;
    if (bp_mode) begin
      avail = bp_pat[bp_idx[1:0]];
      bp_idx = bp_idx + 1;
    end else begin
      avail = avail_cmd;
    end
  end

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: the expected queue doubles as the buffer-occupancy model.
  always @(negedge clk) begin
    int ref_e;
    if (mon_en) begin
      check1("valid_model", send_valid, exp_q.size() != 0);
      check1("tready_model", tready, run_phase && (exp_q.size() < 2));
      if (hold_vld && send_valid) check64("hold_stable", send_tdata, hold_dat);
      hold_vld = send_valid && !avail;
      hold_dat = send_tdata;
      if (send_valid && avail) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got 0x%0h expected none (cycle %0d)", send_tdata, cyc);
        end else begin
          check64("beat_data", send_tdata, exp_q.pop_front());
        end
        last_pop_edge = cyc + 1;
        if (first_pop_edge < 0) first_pop_edge = cyc + 1;
      end
      if (tx_done) begin
        done_count++;
        check1("done_allowed", done_allowed, 1'b1);
        ref_e = (done_ref >= 0) ? done_ref : last_pop_edge;
        if (done_allowed) checki("done_gap", cyc - ref_e, DW);
        check1("busy_low_at_done", tx_busy, 1'b0);
        check1("busy_high_before_done", prev_busy, 1'b1);
      end
      prev_busy = tx_busy;
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic last);
    int n = 0;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    @(negedge clk);
    while (!tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tready) begin
      n_tests++;
      n_fail++;
      $display("FAIL tready_timeout: got 0 expected 1 for beat 0x%0h", d);
    end else begin
      @(posedge clk);
      #1;
      exp_q.push_back(d);
      if (last) run_phase = 0;
    end
    if (!tready) begin
      @(posedge clk);
      #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic start_xfer();
    sending = 1'b0;
    @(posedge clk);
    #1;
    sending = 1'b1;
    @(posedge clk);
    #1;
    run_phase      = 1;
    first_pop_edge = -1;
    done_ref       = -1;
    check1("busy_after_start", tx_busy, 1'b1);
`ifdef TRANSPORT_DOWN_FRAME_CNT_EN
    checki("beat_cnt_cleared", int'(beat_cnt), 0);
`endif
  endtask

  task automatic wait_done(input int max);
    int c0 = done_count;
    int n = 0;
    while (done_count == c0 && n < max) begin
      @(posedge clk);
      n++;
    end
    #1;
    checki("done_seen", done_count, c0 + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; tvalid = 1'b0; tdata = 64'd0; tlast = 1'b0;
    busy_in = 1'b0; sending = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst_tready", tready, 1'b0);
    check1("rst_valid", send_valid, 1'b0);
    check64("rst_tdata", send_tdata, 64'd0);
    check1("rst_busy", tx_busy, 1'b0);
    check1("rst_done", tx_done, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    avail_cmd = 1;
    mon_en = 1;

    // Streaming 8 beats with free sink.
    done_allowed = 1;
    start_xfer();
    for (int i = 1; i <= 8; i++) send_beat(64'(i), i == 8);
    wait_done(40);
    done_allowed = 0;
    checki("consecutive_pops", last_pop_edge - first_pop_edge, 7);
`ifdef TRANSPORT_DOWN_FRAME_CNT_EN
    checki("beat_cnt_8", int'(beat_cnt), 8);
`endif
    // Enable still high: must not re-arm.
    repeat (5) @(posedge clk);
    #1;
    check1("held_high_tready", tready, 1'b0);
    check1("held_high_busy", tx_busy, 1'b0);

    // Sink stalls in a 1,0,0,1 pattern.
    done_allowed = 1;
    start_xfer();
    bp_mode = 1;
    for (int i = 0; i < 10; i++) send_beat(64'h100 + 64'(i), i == 9);
    wait_done(80);
    done_allowed = 0;
    bp_mode = 0;

    // Core busy holds off done; a short idle gap must not complete.
    busy_in = 1'b1;
    start_xfer();
    for (int i = 0; i < 5; i++) send_beat(64'h200 + 64'(i), i == 4);
    n = 0;
    while ((exp_q.size() != 0 || send_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checki("drained", exp_q.size(), 0);
    repeat (20) @(posedge clk);
    #1;
    busy_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    busy_in = 1'b1;
    @(posedge clk);
    #1;
    done_ref = cyc;
    done_allowed = 1;
    busy_in = 1'b0;
    wait_done(20);
    done_allowed = 0;
`ifdef TRANSPORT_DOWN_FRAME_CNT_EN
    checki("beat_cnt_5", int'(beat_cnt), 5);
`endif

    // Abort with two beats buffered.
    start_xfer();
    send_beat(64'h301, 1'b0);
    send_beat(64'h302, 1'b0);
    avail_cmd = 0;
    send_beat(64'h303, 1'b0);
    sending = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    run_phase = 0;
    check1("abort_valid", send_valid, 1'b0);
    check1("abort_tready", tready, 1'b0);
    check1("abort_busy", tx_busy, 1'b0);
    avail_cmd = 1;
    repeat (10) @(posedge clk);
    #1;
    checki("no_done_after_abort", done_count, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
